// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame geometry.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator, one tick every DIV clocks.
module uart_baud_tick #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned RAW_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (RAW_DIV > 1) ? RAW_DIV : 1;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            tick <= (cnt == CNT_LAST);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a one-deep output holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_datastream,
    input  logic                 rx_data_ready,
    output logic                 rx_data_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int unsigned SC_W = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W = $clog2(DATA_BITS);
    localparam logic [SC_W-1:0] MID_START   = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] LAST_SAMPLE = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 tick;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic [SC_W-1:0]      sample_cnt;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 stop_sample;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign stop_sample = (state == STOP) && tick && (sample_cnt == LAST_SAMPLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_prev       <= 1'b1;
            state         <= IDLE;
            sample_cnt    <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            rx_meta       <= rx_datastream;
            rx_sync       <= rx_meta;
            rx_prev       <= rx_sync;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;

            // Holding register: a same-cycle handshake frees the slot for a new byte.
            if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
            if (stop_sample && rx_sync) begin
                if (!rx_data_valid || rx_data_ready) begin
                    rx_data       <= shift;
                    rx_data_valid <= 1'b1;
                end else begin
                    overrun_error <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state      <= START;
                        sample_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt == MID_START) begin
                            sample_cnt <= '0;
                            bit_cnt    <= '0;
                            state      <= rx_sync ? IDLE : DATA;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt <= '0;
                            shift      <= {rx_sync, shift[DATA_BITS-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (sample_cnt == LAST_SAMPLE) begin
                            sample_cnt <= '0;
                            state      <= IDLE;
                            if (!rx_sync) begin
                                framing_error <= 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned OS  = 16;
    localparam int unsigned BIT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_line;
    logic       ready;
    logic       rx_data_valid;
    logic [7:0] rx_data;
    logic       framing_error;
    logic       overrun_error;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned valid_cyc = 0;
    int unsigned fe_cyc    = 0;
    int unsigned oe_cyc    = 0;
    logic [7:0]  exp_q[$];

    uart_rx #(
        .CLK_FREQ  (1_843_200),
        .BAUD      (115200),
        .OVERSAMPLE(OS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_datastream(rx_line),
        .rx_data_ready(ready),
        .rx_data_valid(rx_data_valid),
        .rx_data      (rx_data),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        valid_cyc = 0;
        fe_cyc    = 0;
        oe_cyc    = 0;
    endtask

    // Drives one full frame starting just after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_line = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx_line = stop_bit;
        repeat (BIT) @(posedge clk);
        #1;
        rx_line = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Output monitor: counts pulses and pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_data_valid) valid_cyc++;
            if (framing_error) fe_cyc++;
            if (overrun_error) oe_cyc++;
            if (rx_data_valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    check("sb_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic found;
        rst_n   = 1'b0;
        rx_line = 1'b1;
        ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(rx_data_valid), 32'd0);
        check("rst_data",  32'(rx_data),       32'd0);
        check("rst_fe",    32'(framing_error), 32'd0);
        check("rst_oe",    32'(overrun_error), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Good byte with host always ready
        clear_counts();
        ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check("a5_valid_cycles", valid_cyc, 32'd1);
        check("a5_fe", fe_cyc, 32'd0);
        check("a5_oe", oe_cyc, 32'd0);
        check("a5_consumed", exp_q.size(), 32'd0);

        // Short low glitch while idle
        clear_counts();
        rx_line = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_line = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_valid", valid_cyc, 32'd0);
        check("glitch_errs", fe_cyc + oe_cyc, 32'd0);
        check("glitch_idle", 32'(dut.state == IDLE), 32'd1);

        // Bad stop bit, then the same byte framed correctly
        clear_counts();
        send_frame(8'h3C, 1'b0);
        check("fe_pulse_cycles", fe_cyc, 32'd1);
        check("fe_no_valid", valid_cyc, 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        check("fe_recover_consumed", exp_q.size(), 32'd0);
        check("fe_recover_fe", fe_cyc, 32'd1);

        // Overrun: host stalls across two bytes
        clear_counts();
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        check("ovr_first_valid", 32'(rx_data_valid), 32'd1);
        send_frame(8'h22, 1'b1);
        check("ovr_pulse_cycles", oe_cyc, 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        check("ovr_valid_kept", 32'(rx_data_valid), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_drop", 32'(rx_data_valid), 32'd0);
        check("ovr_consumed", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;

        // Handshake on the exact delivery cycle of the next byte
        clear_counts();
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                found = 1'b0;
                for (int i = 0; i < 400 && !found; i++) begin
                    @(posedge clk);
                    #1;
                    if (dut.state == STOP && 32'(dut.sample_cnt) == OS - 1 && dut.tick) found = 1'b1;
                end
                check("same_cycle_deliver_seen", 32'(found), 32'd1);
                ready = 1'b1;
                @(negedge clk);
                check("same_cycle_valid0", 32'(rx_data_valid), 32'd1);
                check("same_cycle_data0",  32'(rx_data),       32'h11);
                @(negedge clk);
                check("same_cycle_valid1", 32'(rx_data_valid), 32'd1);
                check("same_cycle_data1",  32'(rx_data),       32'h22);
            end
        join
        check("same_cycle_no_oe", oe_cyc, 32'd0);
        check("same_cycle_consumed", exp_q.size(), 32'd0);
        check("same_cycle_valid_drop", 32'(rx_data_valid), 32'd0);

        // Reset in the middle of data bit 3 with a byte still pending
        ready = 1'b0;
        send_frame(8'h77, 1'b1);
        check("pre_rst_pending", 32'(rx_data_valid), 32'd1);
        rx_line = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx_line = (8'h5A >> i) & 8'h01 ? 1'b1 : 1'b0;
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx_line = 1'b1;
        repeat (BIT / 2) @(posedge clk);
        #1;
        check("mid_rst_in_data", 32'(dut.state == DATA), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rx_data_valid), 32'd0);
        check("mid_rst_data",  32'(rx_data),       32'd0);
        check("mid_rst_fe",    32'(framing_error), 32'd0);
        check("mid_rst_oe",    32'(overrun_error), 32'd0);
        check("mid_rst_idle",  32'(dut.state == IDLE), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rx_line = 1'b1;
        rst_n   = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        clear_counts();
        ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        check("post_rst_consumed", exp_q.size(), 32'd0);
        check("post_rst_valid_cycles", valid_cyc, 32'd1);
        check("post_rst_errs", fe_cyc + oe_cyc, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit; SHALL be even and at least 4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_datastream, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port rx_data_ready, input, 1 bit: host accepts the byte.
REQ-008 SHALL have port rx_data_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_data, output, 8 bits: received byte.
REQ-010 SHALL have port framing_error, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun_error, output, 1 bit: one-cycle pulse when a byte is dropped.

Function
REQ-012 SHALL pass rx_datastream through a 2-flop synchronizer before any use.
REQ-013 SHALL generate a sample tick every DIV = max(1, CLK_FREQ/(BAUD*OVERSAMPLE)) cycles (integer floor); the tick counter SHALL wrap from DIV-1 to 0.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: a synchronized 1->0 transition SHALL enter START and clear the sample counter; a line held low SHALL not retrigger.
REQ-016 START: at sample OVERSAMPLE/2-1, line high SHALL return to IDLE (glitch reject, no outputs); line low SHALL enter DATA with the sample counter cleared.
REQ-017 DATA: every OVERSAMPLE ticks SHALL sample one bit into the shift register LSB first; after bit 7 SHALL enter STOP.
REQ-018 STOP: at the stop-bit mid-sample, line high SHALL deliver the byte; line low SHALL pulse framing_error for exactly one cycle, discard the byte, and return to IDLE.
REQ-019 Delivery SHALL occur on the cycle after the stop mid-sample tick: rx_data loaded and rx_data_valid=1.
REQ-020 rx_data_valid SHALL stay high and rx_data SHALL stay stable until a cycle with rx_data_valid&&rx_data_ready; valid SHALL drop on the next cycle unless REQ-022 applies.
REQ-021 Delivery while valid is high with no handshake in the same cycle SHALL pulse overrun_error for one cycle, drop the new byte, and keep the old one.
REQ-022 Delivery in the same cycle as a handshake SHALL load the new byte, keep valid high, and not signal overrun.
REQ-023 The FSM SHALL return to IDLE after STOP regardless of the host state; reception SHALL never stall on rx_data_ready.
REQ-024 rx_data_valid SHALL never depend combinationally on rx_data_ready.

Reset
REQ-025 While rst_n=0, SHALL force rx_data_valid=0, rx_data=8'h00, framing_error=0, overrun_error=0, FSM to IDLE, and all counters to 0; synchronizer flops SHALL reset to 1.
REQ-026 Reset mid-byte SHALL discard the partial byte; the first byte after reset release SHALL be received normally.

Structure
REQ-027 Package uart_pkg SHALL hold the rx_state_t enum and the constant DATA_BITS=8, shared with the transmitter.
REQ-028 The tick generator SHALL be a separate sub-module, uart_baud_tick (params CLK_FREQ, BAUD, OVERSAMPLE; output tick), reusable by the transmitter.

Verification (CLK_FREQ=1_843_200, BAUD=115200, so DIV=1 and 16 cycles/bit)
REQ-029 Send 0xA5 with rx_data_ready=1 -> rx_data=0xA5, valid high for exactly 1 cycle, no error pulses.
REQ-030 Drive a 4-cycle low glitch while idle -> no valid, no errors, FSM back in IDLE.
REQ-031 Send 0x3C with stop bit=0 -> framing_error high for 1 cycle, valid stays 0; a following 0x3C with a good stop bit is received correctly.
REQ-032 Send 0x11 then 0x22 with ready=0 -> valid with 0x11; at 0x22 completion overrun_error pulses once and rx_data stays 0x11; then ready=1 -> valid drops.
REQ-033 Assert ready exactly on the 0x22 delivery cycle while 0x11 is pending -> valid stays continuously high, rx_data changes 0x11 to 0x22, no overrun.
REQ-034 Assert rst_n=0 during DATA bit 3 -> all outputs 0 immediately; after release, 0x5A is received correctly.
